// File: rtl/zld_b_pkg.sv
// Shared constants for the 7->8 bit zero run-length codec.
// The encoder and decoder both import this package.
package zld_b_pkg;

  localparam int ZL_TOK_W   = 8;
  localparam int ZL_DAT_W   = 7;
  localparam int ZL_RUN_BIT = 7;

  localparam logic ZL_LIT = 1'b0;
  localparam logic ZL_RUN = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } zl_state_e;

  function automatic logic zl_is_run(input logic [ZL_TOK_W-1:0] tok);
    return tok[ZL_RUN_BIT] == ZL_RUN;
  endfunction

endpackage

// File: rtl/zld_run_ctr.sv
// Loadable down-counter tracking the zeros still owed by a run token.
// Decrement stops at zero, so the count never wraps.
module zld_run_ctr #(
  parameter int W = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_one,
  output logic         is_zero
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // next count: load wins over decrement
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one  = (cnt_q == W'(1));
  assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/zld_b.sv
// Zero run-length decoder: expands literal and zero-run tokens into a
// registered 7-bit word stream with valid/backpressure on both sides.
module zld_b
  import zld_b_pkg::*;
#(
  parameter int Wi = ZL_TOK_W,
  parameter int Wo = ZL_DAT_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [Wi-1:0] i_d,
  input  logic          i_v,
  output logic          i_b,
  output logic [Wo-1:0] o_d,
  output logic          o_v,
  input  logic          o_b
);

  zl_state_e     state_d, state_q;
  logic [Wo-1:0] o_d_d, o_d_q;
  logic          o_v_d, o_v_q;
  logic          adv;
  logic [Wo-1:0] field;
  logic          ctr_load, ctr_dec, ctr_one, ctr_zero;

  assign field = i_d[Wo-1:0];

  zld_run_ctr #(.W(Wo)) u_ctr (
    .clock    (clock),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (field),
    .dec      (ctr_dec),
    .is_one   (ctr_one),
    .is_zero  (ctr_zero)
  );

  // token acceptance, run sequencing and output-slot refill
  always_comb begin
    adv      = !o_v_q || !o_b;
    state_d  = state_q;
    o_d_d    = o_d_q;
    o_v_d    = o_v_q;
    i_b      = 1'b1;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        i_b = !adv;
        if (i_v && adv) begin
          o_v_d = 1'b1;
          if (!zl_is_run(i_d)) begin
            o_d_d = field;
          end else begin
            o_d_d = '0;
            // a zero field is a run of one: fully emitted right now
            if (field != '0) begin
              ctr_load = 1'b1;
              state_d  = ST_RUN;
            end else begin
              state_d  = ST_IDLE;
            end
          end
        end else if (adv) begin
          o_v_d = 1'b0;
        end else begin
          o_v_d = o_v_q;
        end
      end
      ST_RUN: begin
        i_b = 1'b1;
        if (adv) begin
          o_d_d   = '0;
          o_v_d   = 1'b1;
          ctr_dec = !ctr_zero;
          if (ctr_one || ctr_zero) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        o_v_d   = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      o_d_q   <= '0;
      o_v_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      o_d_q   <= o_d_d;
      o_v_q   <= o_v_d;
    end
  end

  assign o_d = o_d_q;
  assign o_v = o_v_q;

endmodule

// File: tb/tb_zld_b.sv
// Self-checking bench for zld_b: directed scenarios plus a random stream,
// all checked against a queue-of-words model of the decoded output.
module tb_zld_b;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] i_d;
  logic       i_v, i_b;
  logic [6:0] o_d;
  logic       o_v, o_b;

  int checks   = 0;
  int failures = 0;

  // Model: every decoded word not yet consumed, oldest first; m_ov means the
  // oldest one should currently be sitting in the output register.
  logic [6:0] exp_q[$];
  logic       m_ov;

  typedef struct packed {
    logic       ib;
    logic       ov;
    logic [6:0] od;
    logic       acc;
    logic       take;
  } smp_t;

  always #5 clock = ~clock;

  zld_b dut (
    .clock (clock),
    .reset (reset),
    .i_d   (i_d),
    .i_v   (i_v),
    .i_b   (i_b),
    .o_d   (o_d),
    .o_v   (o_v),
    .o_b   (o_b)
  );

  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic b,
                       output smp_t obs, output smp_t ex);
    logic adv;
    i_v = v;
    i_d = v ? d : 8'bx;
    o_b = b;
    #1;
    obs.ib   = i_b;
    obs.ov   = o_v;
    obs.od   = o_d;
    obs.acc  = v && !i_b;
    obs.take = o_v && !b;
    ex.ov    = m_ov;
    ex.od    = m_ov ? exp_q[0] : 7'd0;
    ex.ib    = ((exp_q.size() - int'(m_ov)) > 0) || (m_ov && b);
    ex.acc   = v && !ex.ib;
    ex.take  = m_ov && !b;
    adv      = !m_ov || !b;
    if (ex.take) void'(exp_q.pop_front());
    if (ex.acc) begin
      if (d[7]) repeat (int'(d[6:0]) + 1) exp_q.push_back(7'd0);
      else exp_q.push_back(d[6:0]);
    end
    if (adv) m_ov = (exp_q.size() > 0);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (o_v !== 1'b0) begin failures++; $display("FAIL reset_ov got=%b exp=0", o_v); end
    checks++;
    if (o_d !== 7'd0) begin failures++; $display("FAIL reset_od got=%h exp=00", o_d); end
    checks++;
    if (i_b !== 1'b0) begin failures++; $display("FAIL reset_ib got=%b exp=0", i_b); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_literals();
    logic [7:0] lits[3] = '{8'h05, 8'h00, 8'h7F};
    smp_t o, e;
    for (int k = 0; k < 6; k++) begin
      cycle(k < 3, (k < 3) ? lits[k] : 8'h00, 1'b0, o, e);
      checks++;
      if (o.ib !== e.ib || o.ov !== e.ov || (e.ov && o.od !== e.od)) begin
        failures++;
        $display("FAIL literals c%0d got ib=%b ov=%b od=%h exp ib=%b ov=%b od=%h", k, o.ib, o.ov, o.od, e.ib, e.ov, e.od);
      end
      if (k >= 1 && k <= 3) begin
        checks++;
        if (o.ov !== 1'b1 || o.od !== lits[k-1][6:0]) begin
          failures++;
          $display("FAIL literal_latency c%0d got ov=%b od=%h exp ov=1 od=%h", k, o.ov, o.od, lits[k-1][6:0]);
        end
      end
    end
  endtask

  task automatic test_run_one();
    smp_t o, e;
    int ib_hi = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(k < 2, (k == 0) ? 8'h80 : 8'h11, 1'b0, o, e);
      ib_hi += int'(o.ib);
      checks++;
      if (o.ib !== e.ib || o.ov !== e.ov || (e.ov && o.od !== e.od)) begin
        failures++;
        $display("FAIL run_one c%0d got ib=%b ov=%b od=%h exp ib=%b ov=%b od=%h", k, o.ib, o.ov, o.od, e.ib, e.ov, e.od);
      end
    end
    checks++;
    if (ib_hi !== 0) begin failures++; $display("FAIL run_one_ib got=%0d exp=0", ib_hi); end
  endtask

  // Run token followed by a literal held valid until taken.
  task automatic test_run_held(input logic [7:0] run_tok, input logic [7:0] lit,
                               input int exp_ib, input int exp_zeros);
    smp_t o, e;
    int ib_hi = 0, zeros = 0, k = 0;
    logic got = 1'b0;
    cycle(1'b1, run_tok, 1'b0, o, e);
    while (!got && k < 300) begin
      cycle(1'b1, lit, 1'b0, o, e);
      ib_hi += int'(o.ib);
      if (o.take && o.od == 7'd0) zeros++;
      got = o.acc;
      k++;
      checks++;
      if (o.ib !== e.ib || o.ov !== e.ov || (e.ov && o.od !== e.od)) begin
        failures++;
        $display("FAIL run_held_%h c%0d got ib=%b ov=%b od=%h exp ib=%b ov=%b od=%h", run_tok, k, o.ib, o.ov, o.od, e.ib, e.ov, e.od);
      end
    end
    checks++;
    if (!got) begin failures++; $display("FAIL run_held_timeout_%h got=none exp=accept", run_tok); end
    checks++;
    if (ib_hi !== exp_ib) begin failures++; $display("FAIL run_held_ib_%h got=%0d exp=%0d", run_tok, ib_hi, exp_ib); end
    checks++;
    if (zeros !== exp_zeros) begin failures++; $display("FAIL run_held_zeros_%h got=%0d exp=%0d", run_tok, zeros, exp_zeros); end
    cycle(1'b0, 8'h00, 1'b0, o, e);
    checks++;
    if (o.ov !== 1'b1 || o.od !== lit[6:0]) begin
      failures++;
      $display("FAIL run_held_next_%h got ov=%b od=%h exp ov=1 od=%h", run_tok, o.ov, o.od, lit[6:0]);
    end
    repeat (2) cycle(1'b0, 8'h00, 1'b0, o, e);
  endtask

  task automatic test_backpressure();
    logic bp[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    smp_t o, e, prev;
    logic prev_b = 1'b0;
    int zeros = 0;
    cycle(1'b1, 8'h84, 1'b0, o, e);
    prev = o;
    for (int k = 0; k < 24; k++) begin
      cycle(1'b0, 8'h00, bp[k % 12], o, e);
      if (o.take) zeros++;
      checks++;
      if (o.ib !== e.ib || o.ov !== e.ov || (e.ov && o.od !== e.od)) begin
        failures++;
        $display("FAIL backpressure c%0d got ib=%b ov=%b od=%h exp ib=%b ov=%b od=%h", k, o.ib, o.ov, o.od, e.ib, e.ov, e.od);
      end
      if (prev.ov && prev_b) begin
        checks++;
        if (o.ov !== 1'b1 || o.od !== prev.od) begin
          failures++;
          $display("FAIL stall_hold c%0d got ov=%b od=%h exp ov=1 od=%h", k, o.ov, o.od, prev.od);
        end
      end
      prev   = o;
      prev_b = bp[k % 12];
    end
    checks++;
    if (zeros !== 5) begin failures++; $display("FAIL backpressure_count got=%0d exp=5", zeros); end
  endtask

  task automatic test_reset_midrun();
    smp_t o, e;
    int takes = 0, hits = 0;
    cycle(1'b1, 8'h89, 1'b0, o, e);
    for (int k = 0; k < 10 && takes < 2; k++) begin
      cycle(1'b0, 8'h00, 1'b0, o, e);
      if (o.take) takes++;
    end
    reset = 1'b0;
    #1;
    checks++;
    if (o_v !== 1'b0) begin failures++; $display("FAIL midrun_reset_ov got=%b exp=0", o_v); end
    checks++;
    if (i_b !== 1'b0) begin failures++; $display("FAIL midrun_reset_ib got=%b exp=0", i_b); end
    exp_q.delete();
    m_ov = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle(k == 0, 8'h33, 1'b0, o, e);
      if (o.take) hits++;
      checks++;
      if (o.ib !== e.ib || o.ov !== e.ov || (e.ov && o.od !== e.od)) begin
        failures++;
        $display("FAIL midrun_after c%0d got ib=%b ov=%b od=%h exp ib=%b ov=%b od=%h", k, o.ib, o.ov, o.od, e.ib, e.ov, e.od);
      end
    end
    checks++;
    if (hits !== 1) begin failures++; $display("FAIL midrun_words got=%0d exp=1", hits); end
  endtask

  task automatic test_random();
    smp_t o, e;
    logic [7:0] tok;
    int k = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 1) == 0) tok = {1'b0, 7'($urandom_range(0, 127))};
      else tok = {1'b1, 7'($urandom_range(0, 9))};
      cycle(($urandom_range(0, 2) != 0), tok, ($urandom_range(0, 3) == 0), o, e);
      checks++;
      if (o.ib !== e.ib || o.ov !== e.ov || (e.ov && o.od !== e.od)) begin
        failures++;
        $display("FAIL random c%0d got ib=%b ov=%b od=%h exp ib=%b ov=%b od=%h", n, o.ib, o.ov, o.od, e.ib, e.ov, e.od);
      end
    end
    while ((exp_q.size() > 0 || m_ov) && k < 300) begin
      cycle(1'b0, 8'h00, 1'b0, o, e);
      k++;
      checks++;
      if (o.ib !== e.ib || o.ov !== e.ov || (e.ov && o.od !== e.od)) begin
        failures++;
        $display("FAIL random_drain c%0d got ib=%b ov=%b od=%h exp ib=%b ov=%b od=%h", k, o.ib, o.ov, o.od, e.ib, e.ov, e.od);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL random_drain_timeout got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b0;
    i_v   = 1'b0;
    i_d   = 8'h00;
    o_b   = 1'b0;
    m_ov  = 1'b0;
    test_reset();
    test_literals();
    test_run_one();
    test_run_held(8'h83, 8'h22, 3, 4);
    test_run_held(8'hFF, 8'h44, 127, 128);
    test_backpressure();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
